// File: rtl/exe_stage_module.sv
// rtl/exe_stage_module.sv - ARM execute stage with EX/MEM pipeline register
//
// Computes Val2 (immediate rotate, load/store offset or shifted Rm), the ALU
// result, the new NZCV flags and the branch target, then registers result,
// store data, destination and memory/write-back controls for the memory stage.
//
// Optional build macro: MUL_ITERATIVE_EN
//   defined   : 32-step radix-2 shift-add multiplier, stalls upstream while busy
//   undefined : single-cycle combinational multiply, stall_out tied low
//
// Ports:
//   clk, rst (async, active-low)
//   PC_in, signed_immediate_in       -> branch_address_out, branch_taken_out
//   reg_file_in1/2, shift_operand_in,
//   immediate_in, execute_command_in,
//   status_reg_in, is_mul_in         -> status_bits_out, status_write_en_out
//   mem_read/write_en_in, wb_enable_in,
//   dest_reg_in                      -> registered *_out to memory stage
//   stall_out                        -> upstream hold request
module exe_stage_module #(
    parameter int ADDRESS_LEN          = 32,
    parameter int REGISTER_LEN         = 32,
    parameter int REG_ADDRESS_LEN      = 4,
    parameter int EXECUTE_COMMAND_LEN  = 4,
    parameter int SIGNED_IMMEDIATE_LEN = 24,
    parameter int SHIFT_OPERAND_LEN    = 12
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic [ADDRESS_LEN-1:0]          PC_in,
    input  logic                            mem_read_en_in,
    input  logic                            mem_write_en_in,
    input  logic                            wb_enable_in,
    input  logic                            immediate_in,
    input  logic                            branch_taken_in,
    input  logic                            status_write_enable_in,
    input  logic                            is_mul_in,
    input  logic [EXECUTE_COMMAND_LEN-1:0]  execute_command_in,
    input  logic [REGISTER_LEN-1:0]         reg_file_in1,
    input  logic [REGISTER_LEN-1:0]         reg_file_in2,
    input  logic [REG_ADDRESS_LEN-1:0]      dest_reg_in,
    input  logic [SIGNED_IMMEDIATE_LEN-1:0] signed_immediate_in,
    input  logic [SHIFT_OPERAND_LEN-1:0]    shift_operand_in,
    input  logic [3:0]                      status_reg_in,
    output logic                            branch_taken_out,
    output logic [ADDRESS_LEN-1:0]          branch_address_out,
    output logic [3:0]                      status_bits_out,
    output logic                            status_write_en_out,
    output logic                            stall_out,
    output logic [REGISTER_LEN-1:0]         alu_result_out,
    output logic [REGISTER_LEN-1:0]         store_data_out,
    output logic [REG_ADDRESS_LEN-1:0]      dest_reg_out,
    output logic                            mem_read_en_out,
    output logic                            mem_write_en_out,
    output logic                            wb_enable_out
);

    localparam int MSB = REGISTER_LEN - 1;

    // Branch target: PC+4 plus the word offset
    assign branch_taken_out   = branch_taken_in;
    assign branch_address_out = PC_in + {{(ADDRESS_LEN-SIGNED_IMMEDIATE_LEN-2){signed_immediate_in[SIGNED_IMMEDIATE_LEN-1]}},
                                         signed_immediate_in, 2'b00};

    // Val2 generation
    logic [REGISTER_LEN-1:0]   w_imm_ext;
    logic [2*REGISTER_LEN-1:0] w_imm_rot2;
    logic [2*REGISTER_LEN-1:0] w_rm_rot2;
    logic [4:0]                w_rot_amt;
    logic [4:0]                w_shift_amt;
    logic [REGISTER_LEN-1:0]   w_val2;

    assign w_imm_ext   = {{(REGISTER_LEN-8){1'b0}}, shift_operand_in[7:0]};
    assign w_rot_amt   = {shift_operand_in[11:8], 1'b0};
    assign w_shift_amt = shift_operand_in[11:7];
    // Rotate right by shifting a doubled copy; the low half is the rotated word
    assign w_imm_rot2  = {w_imm_ext, w_imm_ext} >> w_rot_amt;
    assign w_rm_rot2   = {reg_file_in2, reg_file_in2} >> w_shift_amt;

    always_comb begin
        w_val2 = '0;
        if (immediate_in) begin
            w_val2 = w_imm_rot2[MSB:0];
        end else if (mem_read_en_in || mem_write_en_in) begin
            w_val2 = {{(REGISTER_LEN-SHIFT_OPERAND_LEN){1'b0}}, shift_operand_in};
        end else begin
            case (shift_operand_in[6:5])
                2'b00:   w_val2 = reg_file_in2 << w_shift_amt;
                2'b01:   w_val2 = reg_file_in2 >> w_shift_amt;
                2'b10:   w_val2 = $unsigned($signed(reg_file_in2) >>> w_shift_amt);
                default: w_val2 = w_rm_rot2[MSB:0];
            endcase
        end
    end

    // Multiplier
    logic [REGISTER_LEN-1:0] w_product;
    logic                    w_mul_sel;

`ifdef MUL_ITERATIVE_EN
    typedef enum logic [1:0] {S_IDLE, S_BUSY, S_DONE} state_t;

    state_t                  r_state;
    state_t                  w_next_state;
    logic [REGISTER_LEN-1:0] r_mcand;
    logic [REGISTER_LEN-1:0] r_mplier;
    logic [REGISTER_LEN-1:0] r_product;
    logic [4:0]              r_count;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        w_next_state = r_state;
        case (r_state)
            S_IDLE:  if (is_mul_in) w_next_state = S_BUSY;
            S_BUSY:  if (r_count == 5'd31) w_next_state = S_DONE;
            default: w_next_state = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_mcand   <= '0;
            r_mplier  <= '0;
            r_product <= '0;
            r_count   <= '0;
        end else if (r_state == S_IDLE && is_mul_in) begin
            r_mcand   <= reg_file_in1;
            r_mplier  <= reg_file_in2;
            r_product <= '0;
            r_count   <= '0;
        end else if (r_state == S_BUSY) begin
            if (r_mplier[0]) begin
                r_product <= r_product + r_mcand;
            end
            r_mcand  <= r_mcand << 1;
            r_mplier <= r_mplier >> 1;
            r_count  <= r_count + 5'd1;
        end
    end

    assign w_product = r_product;
    // DONE selects the product even if is_mul_in dropped during BUSY
    assign w_mul_sel = (r_state == S_DONE);
    // Gated by rst so the stall releases the moment reset is asserted
    assign stall_out = rst & (((r_state == S_IDLE) & is_mul_in) | (r_state == S_BUSY));
`else
    assign w_product = reg_file_in1 * reg_file_in2;
    assign w_mul_sel = is_mul_in;
    assign stall_out = 1'b0;
`endif

    // ALU and flags
    logic [REGISTER_LEN:0]   w_sum;
    logic [REGISTER_LEN-1:0] w_alu;
    logic                    w_c;
    logic                    w_v;
    logic                    w_keep_flags;

    always_comb begin
        w_sum        = '0;
        w_alu        = '0;
        w_c          = status_reg_in[1];
        w_v          = status_reg_in[0];
        w_keep_flags = 1'b0;
        case (execute_command_in)
            4'b0001: w_alu = w_val2;
            4'b1001: w_alu = ~w_val2;
            4'b0010, 4'b0011: begin
                w_sum = {1'b0, reg_file_in1} + {1'b0, w_val2}
                      + {{REGISTER_LEN{1'b0}}, (execute_command_in[0] & status_reg_in[1])};
                w_alu = w_sum[MSB:0];
                w_c   = w_sum[REGISTER_LEN];
                w_v   = (reg_file_in1[MSB] == w_val2[MSB]) && (w_alu[MSB] != reg_file_in1[MSB]);
            end
            4'b0100, 4'b0101: begin
                // a - b - borrow == a + ~b + carry_in, carry_in = 1 for SUB, C for SBC
                w_sum = {1'b0, reg_file_in1} + {1'b0, ~w_val2}
                      + {{REGISTER_LEN{1'b0}}, (execute_command_in[0] ? status_reg_in[1] : 1'b1)};
                w_alu = w_sum[MSB:0];
                w_c   = w_sum[REGISTER_LEN];
                w_v   = (reg_file_in1[MSB] != w_val2[MSB]) && (w_alu[MSB] != reg_file_in1[MSB]);
            end
            4'b0110: w_alu = reg_file_in1 & w_val2;
            4'b0111: w_alu = reg_file_in1 | w_val2;
            4'b1000: w_alu = reg_file_in1 ^ w_val2;
            default: w_keep_flags = 1'b1;
        endcase
        if (w_mul_sel) begin
            w_alu        = w_product;
            w_c          = status_reg_in[1];
            w_v          = status_reg_in[0];
            w_keep_flags = 1'b0;
        end
    end

    assign status_bits_out     = w_keep_flags ? status_reg_in : {w_alu[MSB], (w_alu == '0), w_c, w_v};
    assign status_write_en_out = status_write_enable_in & ~stall_out;

    // EX/MEM register: a stall inserts a bubble and holds the data fields
    logic [REGISTER_LEN-1:0]    r_alu_result;
    logic [REGISTER_LEN-1:0]    r_store_data;
    logic [REG_ADDRESS_LEN-1:0] r_dest_reg;
    logic                       r_mem_read_en;
    logic                       r_mem_write_en;
    logic                       r_wb_enable;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_alu_result   <= '0;
            r_store_data   <= '0;
            r_dest_reg     <= '0;
            r_mem_read_en  <= 1'b0;
            r_mem_write_en <= 1'b0;
            r_wb_enable    <= 1'b0;
        end else if (stall_out) begin
            r_mem_read_en  <= 1'b0;
            r_mem_write_en <= 1'b0;
            r_wb_enable    <= 1'b0;
        end else begin
            r_alu_result   <= w_alu;
            r_store_data   <= reg_file_in2;
            r_dest_reg     <= dest_reg_in;
            r_mem_read_en  <= mem_read_en_in;
            r_mem_write_en <= mem_write_en_in;
            r_wb_enable    <= wb_enable_in;
        end
    end

    assign alu_result_out   = r_alu_result;
    assign store_data_out   = r_store_data;
    assign dest_reg_out     = r_dest_reg;
    assign mem_read_en_out  = r_mem_read_en;
    assign mem_write_en_out = r_mem_write_en;
    assign wb_enable_out    = r_wb_enable;

endmodule

// File: tb/tb_exe_stage_module.sv
// tb/tb_exe_stage_module.sv - self-checking bench for exe_stage_module
module tb_exe_stage_module;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] PC_in;
    logic        mem_read_en_in, mem_write_en_in, wb_enable_in;
    logic        immediate_in, branch_taken_in, status_write_enable_in, is_mul_in;
    logic [3:0]  execute_command_in;
    logic [31:0] reg_file_in1, reg_file_in2;
    logic [3:0]  dest_reg_in;
    logic [23:0] signed_immediate_in;
    logic [11:0] shift_operand_in;
    logic [3:0]  status_reg_in;
    logic        branch_taken_out;
    logic [31:0] branch_address_out;
    logic [3:0]  status_bits_out;
    logic        status_write_en_out, stall_out;
    logic [31:0] alu_result_out, store_data_out;
    logic [3:0]  dest_reg_out;
    logic        mem_read_en_out, mem_write_en_out, wb_enable_out;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    exe_stage_module dut (
        .clk(clk), .rst(rst), .PC_in(PC_in),
        .mem_read_en_in(mem_read_en_in), .mem_write_en_in(mem_write_en_in),
        .wb_enable_in(wb_enable_in), .immediate_in(immediate_in),
        .branch_taken_in(branch_taken_in), .status_write_enable_in(status_write_enable_in),
        .is_mul_in(is_mul_in), .execute_command_in(execute_command_in),
        .reg_file_in1(reg_file_in1), .reg_file_in2(reg_file_in2),
        .dest_reg_in(dest_reg_in), .signed_immediate_in(signed_immediate_in),
        .shift_operand_in(shift_operand_in), .status_reg_in(status_reg_in),
        .branch_taken_out(branch_taken_out), .branch_address_out(branch_address_out),
        .status_bits_out(status_bits_out), .status_write_en_out(status_write_en_out),
        .stall_out(stall_out), .alu_result_out(alu_result_out),
        .store_data_out(store_data_out), .dest_reg_out(dest_reg_out),
        .mem_read_en_out(mem_read_en_out), .mem_write_en_out(mem_write_en_out),
        .wb_enable_out(wb_enable_out)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] ror32(input logic [31:0] x, input int r);
        if (r == 0) return x;
        return (x >> r) | (x << (32 - r));
    endfunction

    function automatic logic [31:0] model_val2(input logic imm, input logic mem,
                                               input logic [11:0] sh, input logic [31:0] rm);
        int amt;
        logic [31:0] x;
        if (imm) return ror32({24'd0, sh[7:0]}, 2 * int'(sh[11:8]));
        if (mem) return {20'd0, sh};
        amt = int'(sh[11:7]);
        case (sh[6:5])
            2'b00: return rm << amt;
            2'b01: return rm >> amt;
            2'b10: begin
                x = rm;
                for (int i = 0; i < amt; i++) x = {x[31], x[31:1]};
                return x;
            end
            default: return ror32(rm, amt);
        endcase
    endfunction

    task automatic model_alu(input logic [3:0] cmd, input logic [31:0] a, input logic [31:0] b,
                             input logic [3:0] st, output logic [31:0] res, output logic [3:0] nzcv);
        longint ua, ub, sa, sb, u, s, cin, bor;
        logic cf, vf, upd;
        ua = longint'(a); ub = longint'(b);
        sa = longint'($signed(a)); sb = longint'($signed(b));
        cin = longint'(st[1]); bor = 1 - cin;
        cf = st[1]; vf = st[0]; upd = 1'b1; res = 32'd0;
        case (cmd)
            4'b0001: res = b;
            4'b1001: res = ~b;
            4'b0010, 4'b0011: begin
                u = ua + ub + ((cmd == 4'b0011) ? cin : 0);
                s = sa + sb + ((cmd == 4'b0011) ? cin : 0);
                res = u[31:0];
                cf = (u >= 64'h1_0000_0000);
                vf = (s > 64'sd2147483647) || (s < -64'sd2147483648);
            end
            4'b0100, 4'b0101: begin
                u = ((cmd == 4'b0101) ? bor : 0);
                s = sa - sb - u;
                res = a - b - u[31:0];
                cf = (ua >= ub + u);
                vf = (s > 64'sd2147483647) || (s < -64'sd2147483648);
            end
            4'b0110: res = a & b;
            4'b0111: res = a | b;
            4'b1000: res = a ^ b;
            default: upd = 1'b0;
        endcase
        nzcv = upd ? {res[31], (res == 32'd0), cf, vf} : st;
    endtask

    function automatic logic [31:0] pick_operand();
        case ($urandom_range(0, 5))
            0: return 32'h0000_0000;
            1: return 32'h8000_0000;
            2: return 32'hFFFF_FFFF;
            3: return 32'h7FFF_FFFF;
            default: return $urandom;
        endcase
    endfunction

    task automatic clear_inputs();
        PC_in = 0; mem_read_en_in = 0; mem_write_en_in = 0; wb_enable_in = 0;
        immediate_in = 0; branch_taken_in = 0; status_write_enable_in = 0; is_mul_in = 0;
        execute_command_in = 0; reg_file_in1 = 0; reg_file_in2 = 0; dest_reg_in = 0;
        signed_immediate_in = 0; shift_operand_in = 0; status_reg_in = 0;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    logic [31:0] e_val2, e_res, e_baddr;
    logic [3:0]  e_nzcv;
    int          off, cnt;

    initial begin
        clear_inputs();
        rst = 1'b0;
        #12;
        chk("reset_alu", alu_result_out, 0);
        chk("reset_wb", {31'd0, wb_enable_out}, 0);
        chk("reset_dest", {28'd0, dest_reg_out}, 0);
        chk("reset_stall", {31'd0, stall_out}, 0);
        rst = 1'b1;
        tick();

        // ADD with rotated immediate (0xFF ror 4)
        reg_file_in1 = 32'h10; immediate_in = 1; shift_operand_in = 12'h2FF;
        execute_command_in = 4'b0010; wb_enable_in = 1; dest_reg_in = 4'd5;
        tick();
        chk("add_imm_result", alu_result_out, 32'hF000_001F);
        chk("add_imm_wb", {31'd0, wb_enable_out}, 1);
        chk("add_imm_dest", {28'd0, dest_reg_out}, 5);

        // SUBS 5-5
        clear_inputs();
        reg_file_in1 = 5; reg_file_in2 = 5; execute_command_in = 4'b0100;
        status_write_enable_in = 1; wb_enable_in = 1;
        #1;
        chk("subs_nzcv", {28'd0, status_bits_out}, 32'h6);
        chk("subs_swe", {31'd0, status_write_en_out}, 1);
        tick();
        chk("subs_result", alu_result_out, 0);

        // MOV with ASR #4
        clear_inputs();
        reg_file_in2 = 32'h8000_0000; shift_operand_in = 12'h240; execute_command_in = 4'b0001;
        tick();
        chk("asr_result", alu_result_out, 32'hF800_0000);

        // Branch target
        clear_inputs();
        PC_in = 32'h100; signed_immediate_in = 24'hFFFFFE; branch_taken_in = 1;
        #1;
        chk("branch_addr", branch_address_out, 32'hF8);
        chk("branch_taken", {31'd0, branch_taken_out}, 1);
        tick();

        // Randomised non-MUL instructions against the reference model
        for (int n = 0; n < 60; n++) begin
            clear_inputs();
            execute_command_in = 4'($urandom_range(0, 15));
            immediate_in       = ($urandom_range(0, 2) == 0);
            if (!immediate_in && $urandom_range(0, 3) == 0) begin
                mem_read_en_in  = $urandom_range(0, 1);
                mem_write_en_in = !mem_read_en_in;
            end
            wb_enable_in = $urandom_range(0, 1);
            status_write_enable_in = $urandom_range(0, 1);
            branch_taken_in = $urandom_range(0, 1);
            reg_file_in1 = pick_operand();
            reg_file_in2 = pick_operand();
            shift_operand_in = 12'($urandom);
            status_reg_in = 4'($urandom);
            dest_reg_in = 4'($urandom);
            PC_in = $urandom;
            signed_immediate_in = 24'($urandom);
            e_val2 = model_val2(immediate_in, mem_read_en_in | mem_write_en_in, shift_operand_in, reg_file_in2);
            model_alu(execute_command_in, reg_file_in1, e_val2, status_reg_in, e_res, e_nzcv);
            off = int'(signed_immediate_in);
            if (signed_immediate_in[23]) off = off - 32'h0100_0000;
            e_baddr = PC_in + 32'(off * 4);
            #1;
            chk("rnd_nzcv", {28'd0, status_bits_out}, {28'd0, e_nzcv});
            chk("rnd_swe", {31'd0, status_write_en_out}, {31'd0, status_write_enable_in});
            chk("rnd_baddr", branch_address_out, e_baddr);
            tick();
            chk("rnd_result", alu_result_out, e_res);
            chk("rnd_store", store_data_out, reg_file_in2);
            chk("rnd_ctrl", {28'd0, dest_reg_out, mem_read_en_out, mem_write_en_out, wb_enable_out},
                {28'd0, dest_reg_in, mem_read_en_in, mem_write_en_in, wb_enable_in});
        end

`ifdef MUL_ITERATIVE_EN
        // Iterative MUL 7*6
        clear_inputs();
        is_mul_in = 1; reg_file_in1 = 7; reg_file_in2 = 6; wb_enable_in = 1;
        dest_reg_in = 4'd3; status_write_enable_in = 1; status_reg_in = 4'b0011;
        #1;
        chk("mul_stall_start", {31'd0, stall_out}, 1);
        chk("mul_swe_stalled", {31'd0, status_write_en_out}, 0);
        cnt = 0;
        while (stall_out && cnt < 100) begin
            cnt++;
            tick();
            if (cnt == 5 || cnt == 33) chk("mul_bubble_wb", {31'd0, wb_enable_out}, 0);
        end
        chk("mul_stall_cycles", cnt, 33);
        chk("mul_done_nzcv", {28'd0, status_bits_out}, 32'h3);
        chk("mul_done_swe", {31'd0, status_write_en_out}, 1);
        tick();
        is_mul_in = 0; wb_enable_in = 0;
        chk("mul_result", alu_result_out, 42);
        chk("mul_dest", {28'd0, dest_reg_out}, 3);

        // Reset while BUSY with counter at 10
        tick();
        is_mul_in = 1; wb_enable_in = 1; reg_file_in1 = 7; reg_file_in2 = 6;
        repeat (11) tick();
        rst = 1'b0;
        #1;
        chk("rst_mid_stall", {31'd0, stall_out}, 0);
        chk("rst_mid_alu", alu_result_out, 0);
        chk("rst_mid_wb", {31'd0, wb_enable_out}, 0);
        is_mul_in = 0;
        #2;
        rst = 1'b1;
        tick();
        is_mul_in = 1; reg_file_in1 = 3; reg_file_in2 = 3;
        cnt = 0;
        while (stall_out && cnt < 100) begin
            cnt++;
            tick();
        end
        chk("mul2_stall_cycles", cnt, 33);
        tick();
        is_mul_in = 0;
        chk("mul2_result", alu_result_out, 9);
`else
        // Single-cycle MUL 7*6
        clear_inputs();
        is_mul_in = 1; reg_file_in1 = 7; reg_file_in2 = 6; wb_enable_in = 1;
        status_write_enable_in = 1; status_reg_in = 4'b0011;
        #1;
        chk("mul_stall", {31'd0, stall_out}, 0);
        chk("mul_nzcv", {28'd0, status_bits_out}, 32'h3);
        tick();
        chk("mul_result", alu_result_out, 42);
        chk("mul_wb", {31'd0, wb_enable_out}, 1);

        // Asynchronous reset clears registered outputs immediately
        rst = 1'b0;
        #1;
        chk("rst_alu", alu_result_out, 0);
        chk("rst_wb", {31'd0, wb_enable_out}, 0);
        #2;
        rst = 1'b1;
        tick();
        reg_file_in1 = 3; reg_file_in2 = 3;
        tick();
        chk("mul2_result", alu_result_out, 9);
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
